// File: rtl/cat_frame_sched.sv
// cat_frame_sched: sequences a two-segment concatenation buffer.
// Two producers fill their segments concurrently in FILL. Once both segments
// are full, the block drains the concatenated frame to one consumer in DRAIN.
// The buffer is external. This block drives its write, read and clear strobes.
module cat_frame_sched #(
  parameter int NBits        = 16,
  parameter int Seg0Elems    = 8,
  parameter int Seg0PerWrite = 2,
  parameter int Seg1Elems    = 4,
  parameter int Seg1PerWrite = 1,
  parameter int ElemsPerRead = 4,
  parameter int FrameCntBits = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            flush,
  input  logic                            s0_valid,
  output logic                            s0_ready,
  input  logic [Seg0PerWrite*NBits-1:0]   s0_data,
  input  logic                            s1_valid,
  output logic                            s1_ready,
  input  logic [Seg1PerWrite*NBits-1:0]   s1_data,
  output logic                            buf_wr_en0,
  output logic                            buf_wr_en1,
  output logic [Seg0PerWrite*NBits-1:0]   buf_wr_data0,
  output logic [Seg1PerWrite*NBits-1:0]   buf_wr_data1,
  output logic                            buf_rd_en,
  input  logic [ElemsPerRead*NBits-1:0]   buf_rd_data,
  output logic                            buf_clr,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [ElemsPerRead*NBits-1:0]   m_data,
  output logic                            m_last,
  output logic                            busy,
  output logic [FrameCntBits-1:0]         frame_count
);

  localparam int W0  = Seg0Elems / Seg0PerWrite;
  localparam int W1  = Seg1Elems / Seg1PerWrite;
  localparam int R   = (Seg0Elems + Seg1Elems) / ElemsPerRead;
  localparam int C0W = $clog2(W0 + 1);
  localparam int C1W = $clog2(W1 + 1);
  localparam int RCW = $clog2(R + 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                  state;
  logic [C0W-1:0]          cnt0;
  logic [C1W-1:0]          cnt1;
  logic [RCW-1:0]          rcnt;
  logic [FrameCntBits-1:0] fc_q;

  logic           fill_act, drain_act;
  logic [C0W-1:0] cnt0_nxt;
  logic [C1W-1:0] cnt1_nxt;
  logic           last_beat;

  // Reset and flush both silence every handshake and strobe.
  assign fill_act  = !rst_in && !flush && (state == FILL);
  assign drain_act = !rst_in && !flush && (state == DRAIN);

  assign s0_ready     = fill_act && (cnt0 < C0W'(W0));
  assign s1_ready     = fill_act && (cnt1 < C1W'(W1));
  assign buf_wr_en0   = s0_valid && s0_ready;
  assign buf_wr_en1   = s1_valid && s1_ready;
  assign buf_wr_data0 = rst_in ? '0 : s0_data;
  assign buf_wr_data1 = rst_in ? '0 : s1_data;

  assign last_beat    = (rcnt == RCW'(R - 1));
  assign m_valid      = drain_act;
  assign m_data       = drain_act ? buf_rd_data : '0;
  assign m_last       = drain_act && last_beat;
  assign buf_rd_en    = drain_act && m_ready;
  assign buf_clr      = !rst_in && flush;
  assign busy         = !rst_in && (state == DRAIN);
  assign frame_count  = fc_q;

  assign cnt0_nxt = cnt0 + C0W'(buf_wr_en0);
  assign cnt1_nxt = cnt1 + C1W'(buf_wr_en1);

  // Frame sequencer: fill counters, drain beat counter and frame counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= FILL;
      cnt0  <= '0;
      cnt1  <= '0;
      rcnt  <= '0;
      fc_q  <= '0;
    end else if (flush) begin
      state <= FILL;
      cnt0  <= '0;
      cnt1  <= '0;
      rcnt  <= '0;
    end else begin
      case (state)
        FILL: begin
          cnt0 <= cnt0_nxt;
          cnt1 <= cnt1_nxt;
          // The final writes of both segments may land in the same cycle.
          if (cnt0_nxt == C0W'(W0) && cnt1_nxt == C1W'(W1)) state <= DRAIN;
        end
        DRAIN: begin
          if (m_ready) begin
            if (last_beat) begin
              state <= FILL;
              cnt0  <= '0;
              cnt1  <= '0;
              rcnt  <= '0;
              fc_q  <= fc_q + FrameCntBits'(1);
            end else begin
              rcnt <= rcnt + RCW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_cat_frame_sched.sv
// Bench for cat_frame_sched: an external buffer model, a frame-level
// reference model with a beat scoreboard, directed scenarios and random traffic.
module tb_cat_frame_sched;
  localparam int NB  = 16;
  localparam int S0E = 8;
  localparam int S0P = 2;
  localparam int S1E = 4;
  localparam int S1P = 1;
  localparam int EPR = 4;
  localparam int FCB = 5;
  localparam int W0  = S0E / S0P;
  localparam int W1  = S1E / S1P;
  localparam int TOT = S0E + S1E;

  logic clk_in = 0, rst_in = 1, flush = 0;
  logic s0_valid = 0, s1_valid = 0, m_ready = 0;
  logic [S0P*NB-1:0] s0_data = '0;
  logic [S1P*NB-1:0] s1_data = '0;
  logic s0_ready, s1_ready, buf_wr_en0, buf_wr_en1, buf_rd_en, buf_clr;
  logic m_valid, m_last, busy;
  logic [S0P*NB-1:0] buf_wr_data0;
  logic [S1P*NB-1:0] buf_wr_data1;
  logic [EPR*NB-1:0] buf_rd_data, m_data;
  logic [FCB-1:0] frame_count;

  cat_frame_sched #(.NBits(NB), .Seg0Elems(S0E), .Seg0PerWrite(S0P), .Seg1Elems(S1E),
    .Seg1PerWrite(S1P), .ElemsPerRead(EPR), .FrameCntBits(FCB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .buf_wr_en0(buf_wr_en0), .buf_wr_en1(buf_wr_en1),
    .buf_wr_data0(buf_wr_data0), .buf_wr_data1(buf_wr_data1),
    .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .buf_clr(buf_clr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .frame_count(frame_count));

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // External buffer: segment 0 at elements 0..S0E-1, segment 1 after it.
  logic [NB-1:0] mem [0:TOT-1];
  int wp0 = 0, wp1 = 0, rp = 0;

  always_comb begin
    buf_rd_data = '0;
    for (int k = 0; k < EPR; k++) buf_rd_data[k*NB +: NB] = mem[(rp + k) % TOT];
  end

  // Buffer pointers advance on strobes and wrap per segment.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wp0 <= 0; wp1 <= 0; rp <= 0;
    end else if (buf_clr) begin
      wp0 <= 0; wp1 <= 0; rp <= 0;
    end else begin
      if (buf_wr_en0) begin
        for (int j = 0; j < S0P; j++) mem[(wp0 + j) % S0E] <= buf_wr_data0[j*NB +: NB];
        wp0 <= (wp0 + S0P) % S0E;
      end
      if (buf_wr_en1) begin
        for (int j = 0; j < S1P; j++) mem[S0E + (wp1 + j) % S1E] <= buf_wr_data1[j*NB +: NB];
        wp1 <= (wp1 + S1P) % S1E;
      end
      if (buf_rd_en) rp <= (rp + EPR) % TOT;
    end
  end

  // Reference model: accepted elements per segment, pending frame beats.
  bit md_drain = 0;
  int n0 = 0, n1 = 0, fc = 0;
  logic [NB-1:0] q0[$], q1[$], el[$];
  logic [EPR*NB-1:0] expq[$];

  // Monitor: compares every output against the model, pops beats on accept.
  always @(negedge clk_in) begin
    logic e_r0, e_r1, e_mv;
    logic [EPR*NB-1:0] beat;
    if (rst_in) begin
      chk("rst_outs", {s0_ready, s1_ready, buf_wr_en0, buf_wr_en1, buf_rd_en, buf_clr,
                       m_valid, m_last, busy}, 0);
      chk("rst_fc", frame_count, 0);
      md_drain = 0; n0 = 0; n1 = 0; fc = 0;
      q0.delete(); q1.delete(); expq.delete();
    end else begin
      e_r0 = !md_drain && !flush && n0 < W0;
      e_r1 = !md_drain && !flush && n1 < W1;
      e_mv = md_drain && !flush;
      chk("s0_ready", s0_ready, e_r0);
      chk("s1_ready", s1_ready, e_r1);
      chk("wr_en0", buf_wr_en0, e_r0 && s0_valid);
      chk("wr_en1", buf_wr_en1, e_r1 && s1_valid);
      chk("m_valid", m_valid, e_mv);
      chk("rd_en", buf_rd_en, e_mv && m_ready);
      chk("buf_clr", buf_clr, flush);
      chk("busy", busy, md_drain);
      chk("frame_count", frame_count, fc % (1 << FCB));
      if (e_r0 && s0_valid) chk("wr_data0", buf_wr_data0, s0_data);
      if (e_r1 && s1_valid) chk("wr_data1", buf_wr_data1, s1_data);
      if (e_mv && expq.size() > 0) begin
        chk("m_data", m_data, expq[0]);
        chk("m_last", m_last, expq.size() == 1);
      end
      if (flush) begin
        md_drain = 0; n0 = 0; n1 = 0;
        q0.delete(); q1.delete(); expq.delete();
      end else if (md_drain) begin
        if (m_ready) begin
          void'(expq.pop_front());
          if (expq.size() == 0) begin
            md_drain = 0; n0 = 0; n1 = 0; fc++;
          end
        end
      end else begin
        if (e_r0 && s0_valid) begin
          for (int j = 0; j < S0P; j++) q0.push_back(s0_data[j*NB +: NB]);
          n0++;
        end
        if (e_r1 && s1_valid) begin
          for (int j = 0; j < S1P; j++) q1.push_back(s1_data[j*NB +: NB]);
          n1++;
        end
        if (n0 == W0 && n1 == W1) begin
          el = q0;
          foreach (q1[i]) el.push_back(q1[i]);
          for (int b = 0; b < TOT / EPR; b++) begin
            beat = '0;
            for (int k = 0; k < EPR; k++) beat[k*NB +: NB] = el[b*EPR + k];
            expq.push_back(beat);
          end
          q0.delete(); q1.delete();
          md_drain = 1;
        end
      end
    end
  end

  // Observed values of the last driven cycle, sampled at the falling edge.
  logic o_mv, o_last, o_rd, o_wr0, o_r0, o_clr, o_busy;

  task automatic cyc(input bit v0, input bit v1, input bit mr, input bit fl);
    s0_valid = v0; s1_valid = v1; m_ready = mr; flush = fl;
    s0_data = (S0P*NB)'({$urandom, $urandom});
    s1_data = (S1P*NB)'({$urandom, $urandom});
    @(negedge clk_in);
    o_mv = m_valid; o_last = m_last; o_rd = buf_rd_en; o_wr0 = buf_wr_en0;
    o_r0 = s0_ready; o_clr = buf_clr; o_busy = busy;
    @(posedge clk_in); #1;
  endtask

  initial begin
    int first, beats, lastat, wr0s, r0at5, rds, acc, frames;
    bit saw0;
    bit mr_pat [6] = '{1, 0, 0, 1, 0, 1};
    repeat (3) @(posedge clk_in);
    #1 rst_in = 0;

    // 1: concurrent back-to-back fill, then drain with ready high
    first = 0; beats = 0; lastat = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc(c <= 4, c <= 4, 1, 0);
      if (o_mv && first == 0) first = c;
      if (o_mv) begin beats++; if (o_last) lastat = beats; end
    end
    chk("t1_first_mvalid", first, 5);
    chk("t1_beats", beats, 3);
    chk("t1_last_beat", lastat, 3);
    chk("t1_fc", frame_count, 1);

    // 2: s0 completes early and holds valid; s1 delayed
    first = 0; wr0s = 0; r0at5 = 1;
    for (int c = 1; c <= 16; c++) begin
      cyc(c <= 14, c >= 11 && c <= 14, 0, 0);
      if (o_wr0) wr0s++;
      if (c == 5) r0at5 = o_r0;
      if (o_mv && first == 0) first = c;
    end
    chk("t2_wr0_count", wr0s, 4);
    chk("t2_s0_ready_c5", r0at5, 0);
    chk("t2_first_mvalid", first, 15);

    // 3: drain under toggling m_ready
    rds = 0; acc = 0; lastat = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(0, 0, mr_pat[c], 0);
      if (o_rd) rds++;
      if (o_mv && mr_pat[c]) begin acc++; if (o_last) lastat = acc; end
    end
    chk("t3_rd_pulses", rds, 3);
    chk("t3_last_on", lastat, 3);
    chk("t3_fc", frame_count, 2);
    cyc(0, 0, 0, 0);
    chk("t3_fill_mvalid", o_mv, 0);
    chk("t3_fill_ready", o_r0, 1);

    // 4: flush mid-fill, then a full frame still needs 4+4 writes
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1);
    chk("t4_clr", o_clr, 1);
    chk("t4_no_wr", o_wr0, 0);
    cyc(0, 0, 0, 0);
    chk("t4_clr_one_cycle", o_clr, 0);
    for (int c = 1; c <= 4; c++) cyc(1, 1, 0, 0);
    chk("t4_not_yet", o_mv, 0);
    chk("t4_fc", frame_count, 2);
    // 5: flush in DRAIN after one beat
    cyc(0, 0, 1, 0);
    chk("t5_beat1", o_rd, 1);
    cyc(0, 0, 1, 1);
    chk("t5_flush_mv", o_mv, 0);
    chk("t5_flush_rd", o_rd, 0);
    cyc(0, 0, 1, 0);
    chk("t5_after_mv", o_mv, 0);
    chk("t5_after_busy", o_busy, 0);
    chk("t5_fc", frame_count, 2);

    // 6: async reset between edges mid-DRAIN
    for (int c = 1; c <= 4; c++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_in_drain", o_mv, 1);
    #2 rst_in = 1;
    #1;
    chk("t6_async_outs", {s0_ready, s1_ready, m_valid, busy, buf_rd_en, buf_wr_en0,
                          buf_clr, m_last}, 0);
    chk("t6_async_fc", frame_count, 0);
    @(posedge clk_in); #1 rst_in = 0;
    cyc(0, 0, 0, 0);
    chk("t6_ready_back", o_r0, 1);
    for (int c = 1; c <= 4; c++) cyc(1, 1, 1, 0);
    for (int c = 1; c <= 3; c++) cyc(0, 0, 1, 0);
    chk("t6_fc", frame_count, 1);

    // 7: frame counter wrap at 2^FCB
    frames = 0; saw0 = 0;
    for (int c = 0; c < 600 && frames < (1 << FCB); c++) begin
      cyc(1, 1, 1, 0);
      if (o_mv && o_last) frames++;
      if (frame_count == 0) saw0 = 1;
    end
    chk("t7_frames", frames, 1 << FCB);
    chk("t7_wrapped", frame_count, 1);
    chk("t7_saw_zero", saw0, 1);

    // 8: random traffic with occasional flush
    for (int c = 0; c < 3000; c++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
